// File: rtl/mau_pkg.sv
// mau_pkg: access-size codes, FSM state type and lane-mask helper for mem_access_unit
package mau_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  typedef enum logic {IDLE, RMW} state_t;
  function automatic logic [31:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    return size == SIZE_BYTE ? 32'hFF00_0000 >> {off, 3'b000} :
           size == SIZE_HALF ? 32'hFFFF_0000 >> {off, 3'b000} : 32'hFFFF_FFFF;
  endfunction
endpackage

// File: rtl/mau_lane_unit.sv
// mau_lane_unit: big-endian load extract/extend and store lane merge
//   ld_size/ld_off/ld_unsigned/ld_word -> ld_data : extended load lane
//   st_size/st_off/st_wdata/st_word    -> st_data : st_word with target lane replaced
module mau_lane_unit
  import mau_pkg::*;
(
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data,
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  input  logic [31:0] st_word,
  output logic [31:0] st_data
);
  logic [31:0] shifted, placed, mask;
  logic        sign;
  // Shift the addressed lane up to [31:...] so byte/half extraction is offset-free.
  assign shifted = ld_word << {ld_off, 3'b000};
  assign sign    = ~ld_unsigned & shifted[31];
  assign ld_data = ld_size == SIZE_BYTE ? {{24{sign}}, shifted[31:24]} :
                   ld_size == SIZE_HALF ? {{16{sign}}, shifted[31:16]} : ld_word;
  assign placed  = st_size == SIZE_BYTE ? {st_wdata[7:0], 24'h0} >> {st_off, 3'b000} :
                   st_size == SIZE_HALF ? {st_wdata[15:0], 16'h0} >> {st_off, 3'b000} : st_wdata;
  assign mask    = lane_mask(st_size, st_off);
  assign st_data = (st_word & ~mask) | (placed & mask);
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store requests to big-endian 32-bit data memory, RMW for sub-word stores
//   clk, rst (async active-low); req_* handshake in; resp_* one-cycle response out;
//   mem_read/mem_write/mem_address/mem_write_data out, mem_read_data in (combinational)
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int MEM_ADDR_BITS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);
  state_t      state, state_n;
  logic [31:0] word_addr, cap_addr, cap_word, cap_wdata, ld_data, st_data;
  logic [1:0]  cap_off, cap_size;
  logic        accept, err, go_rmw, fin, done_ld;
  logic        unused_hi;
  assign unused_hi = ^req_addr[31:MEM_ADDR_BITS];
  assign word_addr = {{(32 - MEM_ADDR_BITS){1'b0}}, req_addr[MEM_ADDR_BITS-1:2], 2'b00};
  assign req_ready = state == IDLE;
  assign accept    = req_valid & req_ready;
  assign err       = req_size == 2'b11 || (req_size == SIZE_HALF && req_addr[0]) ||
                     (req_size == SIZE_WORD && req_addr[1:0] != 2'b00);
  assign go_rmw    = accept & ~err & req_write & (req_size != SIZE_WORD);
  assign done_ld   = accept & ~err & ~req_write;
  assign fin       = (accept & ~go_rmw) | (state == RMW);
  mau_lane_unit u_lane (
    .ld_size    (req_size),
    .ld_off     (req_addr[1:0]),
    .ld_unsigned(req_unsigned),
    .ld_word    (mem_read_data),
    .ld_data    (ld_data),
    .st_size    (cap_size),
    .st_off     (cap_off),
    .st_wdata   (cap_wdata),
    .st_word    (cap_word),
    .st_data    (st_data)
  );
  always_comb begin
    state_n        = go_rmw ? RMW : IDLE;
    mem_read       = accept & ~err & (~req_write | req_size != SIZE_WORD);
    mem_write      = (state == RMW) | (accept & ~err & req_write & req_size == SIZE_WORD);
    mem_address    = state == RMW ? cap_addr : (mem_read | mem_write) ? word_addr : 32'h0;
    mem_write_data = state == RMW ? st_data : mem_write ? req_wdata : 32'h0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_data  <= 32'h0;
      resp_err   <= 1'b0;
      cap_addr   <= 32'h0;
      cap_word   <= 32'h0;
      cap_wdata  <= 32'h0;
      cap_off    <= 2'b00;
      cap_size   <= 2'b00;
    end else begin
      state      <= state_n;
      resp_valid <= fin;
      if (fin) begin
        resp_data <= done_ld ? ld_data : 32'h0;
        resp_err  <= accept & err;
      end
      if (go_rmw) begin
        cap_addr  <= word_addr;
        cap_word  <= mem_read_data;
        cap_wdata <= req_wdata;
        cap_off   <= req_addr[1:0];
        cap_size  <= req_size;
      end
    end
  end
endmodule
